// File: rtl/yuv_to_rgb_pipe.sv
// Three-stage YUV to RGB converter: BT.601/BT.709 selectable per pixel, one global stall enable.
// Optional saturation counter on sat_cnt when YUV2RGB_SAT_CNT_EN is defined.
module yuv_to_rgb_pipe #(
    parameter int unsigned DW   = 8,
    parameter int unsigned FRAC = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_y,
    input  logic [DW-1:0] in_u,
    input  logic [DW-1:0] in_v,
    input  logic          in_std,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_r,
    output logic [DW-1:0] out_g,
    output logic [DW-1:0] out_b,
    output logic          out_last
`ifdef YUV2RGB_SAT_CNT_EN
    ,
    output logic [15:0]   sat_cnt
`endif
);

    localparam int unsigned W  = DW + FRAC + 4;
    localparam int unsigned CW = FRAC + 3;
    localparam real         SCALE = real'(1 << FRAC);

    localparam logic signed [CW-1:0] K601_R  = CW'($rtoi(1.402  * SCALE + 0.5));
    localparam logic signed [CW-1:0] K601_GU = CW'($rtoi(0.344  * SCALE + 0.5));
    localparam logic signed [CW-1:0] K601_GV = CW'($rtoi(0.714  * SCALE + 0.5));
    localparam logic signed [CW-1:0] K601_B  = CW'($rtoi(1.772  * SCALE + 0.5));
    localparam logic signed [CW-1:0] K709_R  = CW'($rtoi(1.5748 * SCALE + 0.5));
    localparam logic signed [CW-1:0] K709_GU = CW'($rtoi(0.1873 * SCALE + 0.5));
    localparam logic signed [CW-1:0] K709_GV = CW'($rtoi(0.4681 * SCALE + 0.5));
    localparam logic signed [CW-1:0] K709_B  = CW'($rtoi(1.8556 * SCALE + 0.5));

    localparam logic signed [W-1:0] RND  = W'(1 << (FRAC - 1));
    localparam logic signed [W-1:0] MAXV = W'((1 << DW) - 1);

    logic adv;

    logic                 s1_valid_q;
    logic [DW-1:0]        s1_y_q;
    logic signed [DW:0]   s1_u_q;
    logic signed [DW:0]   s1_v_q;
    logic                 s1_std_q;
    logic                 s1_last_q;

    logic                 s2_valid_q;
    logic [DW-1:0]        s2_y_q;
    logic                 s2_last_q;
    logic signed [W-1:0]  s2_pr_q;
    logic signed [W-1:0]  s2_pgu_q;
    logic signed [W-1:0]  s2_pgv_q;
    logic signed [W-1:0]  s2_pb_q;

    logic signed [CW-1:0] k_r, k_gu, k_gv, k_b;
    logic signed [W-1:0]  u_ext, v_ext;
    logic signed [W-1:0]  y_ext, sum_r, sum_g, sum_b;

    // A stalled output freezes the whole pipe, so upstream may only accept when it moves.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    function automatic logic signed [W-1:0] term(input logic signed [W-1:0] p);
        return (p + RND) >>> FRAC;
    endfunction

    function automatic logic clipped(input logic signed [W-1:0] x);
        return x[W-1] | (x > MAXV);
    endfunction

    function automatic logic [DW-1:0] clamp(input logic signed [W-1:0] x);
        logic [DW-1:0] res;
        if (x[W-1]) begin
            res = '0;
        end else if (x > MAXV) begin
            res = '1;
        end else begin
            res = x[DW-1:0];
        end
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            out_valid  <= 1'b0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            s2_valid_q <= s1_valid_q;
            out_valid  <= s2_valid_q;
        end
    end

    // Stage 1: offset-binary chroma to signed by inverting the MSB and sign-extending.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_y_q    <= in_y;
            s1_u_q    <= {~in_u[DW-1], ~in_u[DW-1], in_u[DW-2:0]};
            s1_v_q    <= {~in_v[DW-1], ~in_v[DW-1], in_v[DW-2:0]};
            s1_std_q  <= in_std;
            s1_last_q <= in_last;
        end
    end

    always_comb begin
        if (s1_std_q) begin
            k_r  = K709_R;
            k_gu = K709_GU;
            k_gv = K709_GV;
            k_b  = K709_B;
        end else begin
            k_r  = K601_R;
            k_gu = K601_GU;
            k_gv = K601_GV;
            k_b  = K601_B;
        end
    end

    assign u_ext = W'(s1_u_q);
    assign v_ext = W'(s1_v_q);

    always_ff @(posedge clk) begin
        if (adv) begin
            s2_y_q    <= s1_y_q;
            s2_last_q <= s1_last_q;
            s2_pr_q   <= v_ext * W'(k_r);
            s2_pgu_q  <= u_ext * W'(k_gu);
            s2_pgv_q  <= v_ext * W'(k_gv);
            s2_pb_q   <= u_ext * W'(k_b);
        end
    end

    assign y_ext = W'(s2_y_q);
    assign sum_r = y_ext + term(s2_pr_q);
    assign sum_g = y_ext - term(s2_pgu_q) - term(s2_pgv_q);
    assign sum_b = y_ext + term(s2_pb_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r    <= '0;
            out_g    <= '0;
            out_b    <= '0;
            out_last <= 1'b0;
        end else if (adv && s2_valid_q) begin
            out_r    <= clamp(sum_r);
            out_g    <= clamp(sum_g);
            out_b    <= clamp(sum_b);
            out_last <= s2_last_q;
        end
    end

`ifdef YUV2RGB_SAT_CNT_EN
    logic any_sat;
    logic out_sat_q;

    assign any_sat = clipped(sum_r) | clipped(sum_g) | clipped(sum_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sat_q <= 1'b0;
            sat_cnt   <= '0;
        end else begin
            if (adv && s2_valid_q) begin
                out_sat_q <= any_sat;
            end
            if (out_valid && out_ready && out_sat_q && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_yuv_to_rgb_pipe.sv
// Bench for yuv_to_rgb_pipe: directed spec cases plus random traffic against a real-arithmetic model.
// Define YUV2RGB_SAT_CNT_EN to also exercise the saturation counter.
module tb_yuv_to_rgb_pipe;

    localparam int unsigned DW   = 8;
    localparam int unsigned FRAC = 10;

    typedef struct packed {
        logic          last;
        logic          sat;
        logic [DW-1:0] r;
        logic [DW-1:0] g;
        logic [DW-1:0] b;
    } pix_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_y, in_u, in_v;
    logic          in_std;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_r, out_g, out_b;
    logic          out_last;
`ifdef YUV2RGB_SAT_CNT_EN
    logic [15:0]   sat_cnt;
`endif

    int   n_vec;
    int   n_err;
    int   n_out;
    int   sat_exp;
    pix_t exp_q[$];
    logic        held_v;
    logic [31:0] held;

    yuv_to_rgb_pipe #(.DW(DW), .FRAC(FRAC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_y     (in_y),
        .in_u     (in_u),
        .in_v     (in_v),
        .in_std   (in_std),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_r    (out_r),
        .out_g    (out_g),
        .out_b    (out_b),
        .out_last (out_last)
`ifdef YUV2RGB_SAT_CNT_EN
        ,
        .sat_cnt  (sat_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int kq(input real c);
        return $rtoi(c * real'(1 << FRAC) + 0.5);
    endfunction

    function automatic int tr(input int x, input int k);
        return $rtoi($floor(real'(x * k + (1 << (FRAC - 1))) / real'(1 << FRAC)));
    endfunction

    function automatic int clampc(input int x);
        if (x < 0) return 0;
        if (x > (1 << DW) - 1) return (1 << DW) - 1;
        return x;
    endfunction

    function automatic pix_t model(input int y, input int u, input int v, input bit std,
                                   input bit last);
        real  cr, cgu, cgv, cb;
        int   us, vs, r, g, b, mx;
        pix_t p;
        if (std) begin
            cr = 1.5748; cgu = 0.1873; cgv = 0.4681; cb = 1.8556;
        end else begin
            cr = 1.402;  cgu = 0.344;  cgv = 0.714;  cb = 1.772;
        end
        us = u - (1 << (DW - 1));
        vs = v - (1 << (DW - 1));
        r  = y + tr(vs, kq(cr));
        g  = y - tr(us, kq(cgu)) - tr(vs, kq(cgv));
        b  = y + tr(us, kq(cb));
        mx = (1 << DW) - 1;
        p.last = last;
        p.sat  = (r < 0) || (r > mx) || (g < 0) || (g > mx) || (b < 0) || (b > mx);
        p.r    = DW'(clampc(r));
        p.g    = DW'(clampc(g));
        p.b    = DW'(clampc(b));
        return p;
    endfunction

    // Handshakes seen at the falling edge are exactly those taken at the next rising edge.
    always @(negedge clk) begin
        pix_t e;
        if (rst_n) begin
            if (held_v) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'({out_last, out_r, out_g, out_b}), held);
                held_v = 1'b0;
            end
            if (out_valid && !out_ready) begin
                held   = 32'({out_last, out_r, out_g, out_b});
                held_v = 1'b1;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_r", 32'(out_r), 32'(e.r));
                    chk("out_g", 32'(out_g), 32'(e.g));
                    chk("out_b", 32'(out_b), 32'(e.b));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    if (e.sat && sat_exp != 32'hFFFF) sat_exp++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(in_y), int'(in_u), int'(in_v), in_std, in_last));
            end
        end else begin
            held_v = 1'b0;
        end
    end

    task automatic drive(input int y, input int u, input int v, input bit std, input bit last);
        in_valid = 1'b1;
        in_y     = DW'(y);
        in_u     = DW'(u);
        in_v     = DW'(v);
        in_std   = std;
        in_last  = last;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_sat(input string tag);
`ifdef YUV2RGB_SAT_CNT_EN
        chk(tag, 32'(sat_cnt), 32'(sat_exp));
`else
        chk(tag, 32'(exp_q.size()), 32'd0);
`endif
    endtask

    initial begin
        int i, cyc, n0;
        bit acc;
        n_vec = 0; n_err = 0; n_out = 0; sat_exp = 0; held_v = 1'b0; held = '0;
        rst_n = 1'b1; in_valid = 1'b0; in_y = '0; in_u = '0; in_v = '0;
        in_std = 1'b0; in_last = 1'b0; out_ready = 1'b1;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'({out_r, out_g, out_b, out_last}), 32'd0);
`ifdef YUV2RGB_SAT_CNT_EN
        chk("rst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // Mid-grey BT.601, exact three-cycle latency.
        drive(128, 128, 128, 1'b0, 1'b1);
        @(posedge clk) #1 in_valid = 1'b0;
        @(posedge clk) #1 chk("lat_early", 32'(out_valid), 32'd0);
        @(posedge clk) #1 chk("lat_valid", 32'(out_valid), 32'd1);
        chk("grey601", 32'({out_r, out_g, out_b}), 32'({8'd128, 8'd128, 8'd128}));
        chk("grey_last", 32'(out_last), 32'd1);
        idle(3);
        chk_sat("sat_after_grey");
`ifdef YUV2RGB_SAT_CNT_EN
        chk("sat_grey_zero", 32'(sat_cnt), 32'd0);
`endif

        // All-zero BT.601 clamps R and B.
        drive(0, 0, 0, 1'b0, 1'b0);
        @(posedge clk) #1 in_valid = 1'b0;
        @(posedge clk) #1;
        @(posedge clk) #1 chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero601", 32'({out_r, out_g, out_b}), 32'({8'd0, 8'd135, 8'd0}));
        idle(3);
`ifdef YUV2RGB_SAT_CNT_EN
        chk("sat_zero_one", 32'(sat_cnt), 32'd1);
`endif

        // BT.709 then BT.601 back to back: no bubble on the standard switch.
        drive(128, 128, 255, 1'b1, 1'b0);
        @(posedge clk) #1 drive(128, 128, 128, 1'b0, 1'b1);
        @(posedge clk) #1 in_valid = 1'b0;
        @(posedge clk) #1;
        chk("std709_valid", 32'(out_valid), 32'd1);
        chk("std709", 32'({out_r, out_g, out_b}), 32'({8'd255, 8'd69, 8'd128}));
        @(posedge clk) #1;
        chk("std601_nobubble", 32'(out_valid), 32'd1);
        chk("std601", 32'({out_r, out_g, out_b}), 32'({8'd128, 8'd128, 8'd128}));
        idle(3);
        chk_sat("sat_after_switch");

        // Backpressure: six pixels, output blocked for five cycles.
        n0 = n_out; i = 0; cyc = 0; out_ready = 1'b0;
        while (i < 6 && cyc < 200) begin
            drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                  1'($urandom_range(0, 1)), i == 2 || i == 5);
            #1;
            if (cyc == 3) chk("bp_in_ready_low", 32'(in_ready), 32'd0);
            acc = in_valid && in_ready;
            @(posedge clk) #1;
            if (acc) i++;
            cyc++;
            if (cyc == 5) out_ready = 1'b1;
        end
        chk("bp_all_accepted", 32'(i), 32'd6);
        idle(10);
        chk("bp_count", 32'(n_out - n0), 32'd6);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Random traffic with random stalls.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 9) < 7) begin
                drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk) #1;
        end
        idle(10);
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk_sat("sat_after_rand");

        // Reset with three pixels in flight.
        drive(10, 20, 30, 1'b0, 1'b0);
        @(posedge clk) #1 drive(40, 50, 60, 1'b1, 1'b1);
        @(posedge clk) #1 drive(70, 80, 90, 1'b0, 1'b0);
        @(posedge clk) #1;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'({out_r, out_g, out_b, out_last}), 32'd0);
`ifdef YUV2RGB_SAT_CNT_EN
        chk("midrst_sat_cnt", 32'(sat_cnt), 32'd0);
`endif
        exp_q.delete();
        sat_exp = 0;
        @(negedge clk) rst_n = 1'b1;
        n0 = n_out;
        idle(8);
        chk("no_stale", 32'(n_out - n0), 32'd0);

`ifdef YUV2RGB_SAT_CNT_EN
        // Counter must stick at all-ones.
        drive(0, 0, 0, 1'b0, 1'b0);
        out_ready = 1'b1;
        repeat (65540) @(posedge clk);
        #1;
        idle(6);
        chk("sat_cnt_max", 32'(sat_cnt), 32'hFFFF);
        chk_sat("sat_model_max");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
